// File: rtl/eth_crc_pkg.sv
// Shared constants, FSM state type and byte-wide reflected CRC-32 step for the RX FCS checker.
package eth_crc_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

   // One byte, LSB first (wire order), through the reflected CRC-32 register.
   function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ CRC32_POLY_REFL;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/fcs_delay_line.sv
// 4-deep byte/valid shift register that holds back the trailing FCS bytes of a frame.
// Only built when FCS_STRIP_EN is defined; the default build has no use for it.
`ifdef FCS_STRIP_EN
module fcs_delay_line (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       restart,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] head_data,
   output logic       head_valid
);

   logic [7:0] data_r [4];
   logic [3:0] valid_r;

   // Shift on push; restart reloads with the new frame's first byte; flush empties the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            data_r[i] <= 8'h00;
         end
         valid_r <= 4'b0000;
      end else if (flush) begin
         valid_r <= 4'b0000;
      end else if (restart) begin
         data_r[0] <= din;
         valid_r   <= 4'b0001;
      end else if (push) begin
         data_r[0] <= din;
         data_r[1] <= data_r[0];
         data_r[2] <= data_r[1];
         data_r[3] <= data_r[2];
         valid_r   <= {valid_r[2:0], 1'b1};
      end
   end

   assign head_data  = data_r[3];
   assign head_valid = valid_r[3];

endmodule
`endif

// File: rtl/crc32_rx_check.sv
// Receive-side Ethernet FCS checker: CRC-32 residue check, length check, byte forwarding.
// Optional macro FCS_STRIP_EN: strip the 4 FCS bytes from the forwarded stream.
module crc32_rx_check
   import eth_crc_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       data_valid,
   input  logic       sof,
   input  logic       eof,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   output logic       frame_done,
   output logic       crc_ok,
   output logic       len_err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);

   rx_state_t        state_r, state_next_s;
   logic [31:0]      crc_r, crc_base_s, crc_next_s;
   logic [CNT_W-1:0] count_r, cnt_next_s;
   logic             accept_s, start_s, eof_acc_s;
   logic             frame_done_r, crc_ok_r, len_err_r;
   logic [7:0]       out_data_r;
   logic             out_valid_r, out_last_r;

   // Byte acceptance, next CRC/count and next state.
   always_comb begin
      start_s = data_valid & sof;
      case (state_r)
         IDLE:    accept_s = data_valid & sof;
         RECV:    accept_s = data_valid;
         default: accept_s = 1'b0;
      endcase
      eof_acc_s  = accept_s & eof;
      crc_base_s = start_s ? CRC32_INIT : crc_r;
      crc_next_s = crc32_byte_update(crc_base_s, data);
      if (start_s) begin
         cnt_next_s = CNT_ONE;
      end else if (count_r == CNT_MAX) begin
         cnt_next_s = count_r;
      end else begin
         cnt_next_s = count_r + CNT_ONE;
      end
      if (eof_acc_s) begin
         state_next_s = IDLE;
      end else if (accept_s) begin
         state_next_s = RECV;
      end else begin
         state_next_s = state_r;
      end
   end

   // Frame state, running CRC/count and the held frame verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         crc_r        <= CRC32_INIT;
         count_r      <= CNT_ZERO;
         frame_done_r <= 1'b0;
         crc_ok_r     <= 1'b0;
         len_err_r    <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         frame_done_r <= eof_acc_s;
         if (eof_acc_s) begin
            crc_r     <= CRC32_INIT;
            count_r   <= CNT_ZERO;
            crc_ok_r  <= (crc_next_s == CRC32_RESIDUE);
            len_err_r <= (cnt_next_s < MIN_C) | (cnt_next_s > MAX_C);
         end else if (accept_s) begin
            crc_r   <= crc_next_s;
            count_r <= cnt_next_s;
         end
      end
   end

`ifdef FCS_STRIP_EN
   logic [7:0] head_data_s;
   logic       head_valid_s;
   logic       pop_s;

   fcs_delay_line u_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept_s),
      .restart    (start_s),
      .flush      (eof_acc_s),
      .din        (data),
      .head_data  (head_data_s),
      .head_valid (head_valid_s)
   );

   // A byte leaves the line only when a later byte of the same frame pushes it out.
   assign pop_s = accept_s & ~start_s & head_valid_s;

   // Registered payload-only output stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         out_data_r  <= pop_s ? head_data_s : 8'h00;
         out_valid_r <= pop_s;
         out_last_r  <= pop_s & eof_acc_s;
      end
   end
`else
   // Registered pass-through of every accepted byte, FCS included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         out_data_r  <= accept_s ? data : 8'h00;
         out_valid_r <= accept_s;
         out_last_r  <= eof_acc_s;
      end
   end
`endif

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign out_last   = out_last_r;
   assign frame_done = frame_done_r;
   assign crc_ok     = crc_ok_r;
   assign len_err    = len_err_r;

endmodule

// File: tb/tb_crc32_rx_check.sv
// Directed, table-driven bench for crc32_rx_check (pass-through or FCS_STRIP_EN build).
module tb_crc32_rx_check;

`ifdef FCS_STRIP_EN
   localparam int STRIP = 1;
`else
   localparam int STRIP = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, data_valid, sof, eof;
   logic [7:0] data;
   logic [7:0] out_data;
   logic       out_valid, out_last, frame_done, crc_ok, len_err;

   always #5 clk = ~clk;

   crc32_rx_check dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .data_valid (data_valid),
      .sof        (sof),
      .eof        (eof),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .frame_done (frame_done),
      .crc_ok     (crc_ok),
      .len_err    (len_err)
   );

   typedef struct {
      int   kind;   // 0 literal good, 1 literal corrupted, 2 generated+FCS, 3 single byte
      int   plen;
      int   pat;
      int   gap;
      logic exp_ok;
      logic exp_len;
   } vec_t;

   vec_t       tv [8];
   int         total = 0, bad = 0;
   int         done_cnt = 0, ok_cnt = 0, last_cnt = 0;
   logic [7:0] out_q [$];
   logic [7:0] frm [$];

   // Output monitor.
   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt++;
         if (crc_ok) ok_cnt++;
      end
      if (out_valid) out_q.push_back(out_data);
      if (out_last) last_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_crc(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
         else             c = c >> 1;
      end
      return c;
   endfunction

   function automatic logic [31:0] frm_crc();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = m_crc(c, frm[i]);
      return c;
   endfunction

   task automatic build(input int kind, input int plen, input int pat);
      logic [31:0] f;
      frm.delete();
      case (kind)
         0, 1: begin
            for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
            if (kind == 1) frm[4] = 8'h34;
            frm.push_back(8'h26); frm.push_back(8'h39);
            frm.push_back(8'hF4); frm.push_back(8'hCB);
         end
         2: begin
            for (int i = 0; i < plen; i++) frm.push_back((pat == 0) ? 8'h00 : 8'((i * 7 + 3) & 255));
            f = ~frm_crc();
            frm.push_back(f[7:0]);   frm.push_back(f[15:8]);
            frm.push_back(f[23:16]); frm.push_back(f[31:24]);
         end
         default: frm.push_back(8'h55);
      endcase
   endtask

   task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input int gap_max);
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
         data = 8'($urandom_range(255, 0));
         @(posedge clk);
         #1;
      end
      data = d; sof = s; eof = e; data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
   endtask

   task automatic send_frame(input int gap_max);
      int n;
      n = frm.size();
      for (int i = 0; i < n; i++) drive_byte(frm[i], i == 0, i == n - 1, gap_max);
      check("latency", frame_done, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string name, input int exp_n);
      int mism;
      check({name, "_out_count"}, out_q.size(), exp_n);
      mism = 0;
      for (int i = 0; i < out_q.size() && i < frm.size(); i++)
         if (out_q[i] !== frm[i]) mism++;
      check({name, "_out_data"}, mism, 0);
   endtask

   initial begin
      int   d0, l0, o0, n;
      logic exp_ok;

      tv[0] = '{0, 0,    0, 0, 1'b1, 1'b1};
      tv[1] = '{1, 0,    0, 0, 1'b0, 1'b1};
      tv[2] = '{2, 60,   0, 3, 1'b1, 1'b0};
      tv[3] = '{2, 1515, 1, 0, 1'b1, 1'b1};
      tv[4] = '{3, 0,    0, 0, 1'b0, 1'b1};
      tv[5] = '{2, 1514, 1, 2, 1'b1, 1'b0};
      tv[6] = '{2, 59,   1, 0, 1'b1, 1'b1};
      tv[7] = '{2, 4196, 1, 0, 1'b1, 1'b1};

      rst_n = 1'b0; data = 8'h00; data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
      idle(3);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_crc_ok", crc_ok, 0);
      check("rst_len_err", len_err, 0);
      rst_n = 1'b1;
      idle(2);

      for (int v = 0; v < 8; v++) begin
         build(tv[v].kind, tv[v].plen, tv[v].pat);
         exp_ok = tv[v].exp_ok;
         if (tv[v].kind == 3) exp_ok = (frm_crc() == 32'hDEBB20E3);
         n = frm.size();
         out_q.delete();
         d0 = done_cnt; l0 = last_cnt;
         send_frame(tv[v].gap);
         idle(4);
         check($sformatf("v%0d_done", v), done_cnt - d0, 1);
         check($sformatf("v%0d_crc_ok", v), crc_ok, exp_ok);
         check($sformatf("v%0d_len_err", v), len_err, tv[v].exp_len);
         check($sformatf("v%0d_last", v), last_cnt - l0, (STRIP == 0 || n > 4) ? 1 : 0);
         check_stream($sformatf("v%0d", v), (STRIP == 0) ? n : ((n > 4) ? n - 4 : 0));
      end

      // Abort: sof after 20 bytes of frame A, then complete frame B.
      build(2, 60, 1);
      out_q.delete();
      d0 = done_cnt; l0 = last_cnt;
      for (int i = 0; i < 20; i++) drive_byte(frm[i], i == 0, 1'b0, 0);
      send_frame(0);
      idle(4);
      check("abort_done", done_cnt - d0, 1);
      check("abort_crc_ok", crc_ok, 1);
      check("abort_len_err", len_err, 0);
      check("abort_last", last_cnt - l0, 1);
      check("abort_out_count", out_q.size(), (STRIP == 0) ? 84 : 76);

      // Reset mid-frame at byte 30.
      d0 = done_cnt;
      for (int i = 0; i < 30; i++) drive_byte(frm[i], i == 0, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_crc_ok", crc_ok, 0);
      check("midrst_len_err", len_err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5);
      check("midrst_no_done", done_cnt - d0, 0);
      send_frame(0);
      idle(3);
      check("midrst_next_done", done_cnt - d0, 1);
      check("midrst_next_crc_ok", crc_ok, 1);

      // Back-to-back 64-byte frames, no idle between.
      d0 = done_cnt; o0 = ok_cnt; l0 = last_cnt;
      out_q.delete();
      send_frame(0);
      send_frame(0);
      idle(4);
      check("b2b_done", done_cnt - d0, 2);
      check("b2b_ok", ok_cnt - o0, 2);
      check("b2b_last", last_cnt - l0, 2);
      check("b2b_out_count", out_q.size(), (STRIP == 0) ? 128 : 120);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
